// File: rtl/alu_exec.sv
// rtl/alu_exec.sv - handshaked ALU with a bit-serial shifter (one bit per cycle)
// Shift ops with a non-zero amount walk through SHIFT; everything else completes in one cycle.

`ifndef ALU_SEL_W
`define ALU_SEL_W 4
`define ALU_ADD  4'd1
`define ALU_SUB  4'd2
`define ALU_XOR  4'd3
`define ALU_OR   4'd4
`define ALU_AND  4'd5
`define ALU_SLL  4'd6
`define ALU_SRL  4'd7
`define ALU_SRA  4'd8
`define ALU_SLT  4'd9
`define ALU_SLTU 4'd10
`define ALU_BNE  4'd11
`define ALU_BLT  4'd12
`define ALU_BGE  4'd13
`define ALU_BLTU 4'd14
`define ALU_BGEU 4'd15
`endif

module alu_exec #(
  parameter int XLEN = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [`ALU_SEL_W-1:0] ALUCtl,
  input  logic [XLEN-1:0]       a,
  input  logic [XLEN-1:0]       b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       result,
  output logic                  zero,
  output logic                  br_taken,
  output logic                  err
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                state_q, state_d;
  logic [`ALU_SEL_W-1:0] op_q, op_d;
  logic [XLEN-1:0]       sh_q, sh_d;
  logic [4:0]            cnt_q, cnt_d;
  logic [XLEN-1:0]       result_q, result_d;
  logic                  zero_q, zero_d;
  logic                  br_q, br_d;
  logic                  err_q, err_d;

  logic                  accept;
  logic                  is_shift;
  logic [XLEN-1:0]       eval_res;
  logic                  eval_br;
  logic                  eval_err;
  logic [XLEN-1:0]       sh_next;

  // Single-cycle evaluation; shifts here only cover the zero-amount case.
  always_comb begin
    eval_res = '0;
    eval_br  = 1'b0;
    eval_err = 1'b0;
    case (ALUCtl)
      `ALU_ADD:  eval_res = a + b;
      `ALU_SUB: begin
        eval_res = a - b;
        eval_br  = (a == b);
      end
      `ALU_XOR:  eval_res = a ^ b;
      `ALU_OR:   eval_res = a | b;
      `ALU_AND:  eval_res = a & b;
      `ALU_SLL, `ALU_SRL, `ALU_SRA: eval_res = a;
      `ALU_SLT:  eval_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      `ALU_SLTU: eval_res = {{(XLEN-1){1'b0}}, (a < b)};
      `ALU_BNE: begin
        eval_br  = (a != b);
        eval_res = {{(XLEN-1){1'b0}}, eval_br};
      end
      `ALU_BLT: begin
        eval_br  = ($signed(a) < $signed(b));
        eval_res = {{(XLEN-1){1'b0}}, eval_br};
      end
      `ALU_BGE: begin
        eval_br  = ($signed(a) >= $signed(b));
        eval_res = {{(XLEN-1){1'b0}}, eval_br};
      end
      `ALU_BLTU: begin
        eval_br  = (a < b);
        eval_res = {{(XLEN-1){1'b0}}, eval_br};
      end
      `ALU_BGEU: begin
        eval_br  = (a >= b);
        eval_res = {{(XLEN-1){1'b0}}, eval_br};
      end
      default:   eval_err = 1'b1;
    endcase
  end

  always_comb begin
    is_shift = (ALUCtl == `ALU_SLL) || (ALUCtl == `ALU_SRL) || (ALUCtl == `ALU_SRA);
    case (op_q)
      `ALU_SLL: sh_next = {sh_q[XLEN-2:0], 1'b0};
      `ALU_SRL: sh_next = {1'b0, sh_q[XLEN-1:1]};
      default:  sh_next = {sh_q[XLEN-1], sh_q[XLEN-1:1]};
    endcase
  end

  assign in_ready  = rst_n && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign zero      = zero_q;
  assign br_taken  = br_q;
  assign err       = err_q;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    sh_d     = sh_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    zero_d   = zero_q;
    br_d     = br_q;
    err_d    = err_q;
    case (state_q)
      SHIFT: begin
        sh_d  = sh_next;
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          state_d  = DONE;
          result_d = sh_next;
          zero_d   = (sh_next == '0);
          br_d     = 1'b0;
          err_d    = 1'b0;
        end
      end
      default: begin
        if (accept) begin
          op_d = ALUCtl;
          if (is_shift && (b[4:0] != 5'd0)) begin
            state_d = SHIFT;
            sh_d    = a;
            cnt_d   = b[4:0];
          end else begin
            state_d  = DONE;
            result_d = eval_res;
            zero_d   = (eval_res == '0);
            br_d     = eval_br;
            err_d    = eval_err;
          end
        end else if ((state_q == DONE) && out_ready) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= '0;
      sh_q     <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      br_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      sh_q     <= sh_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      br_q     <= br_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_alu_exec.sv
// tb/tb_alu_exec.sv - vector table, random ops against a reference model, and handshake corner cases
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.

`ifndef ALU_SEL_W
`define ALU_SEL_W 4
`define ALU_ADD  4'd1
`define ALU_SUB  4'd2
`define ALU_XOR  4'd3
`define ALU_OR   4'd4
`define ALU_AND  4'd5
`define ALU_SLL  4'd6
`define ALU_SRL  4'd7
`define ALU_SRA  4'd8
`define ALU_SLT  4'd9
`define ALU_SLTU 4'd10
`define ALU_BNE  4'd11
`define ALU_BLT  4'd12
`define ALU_BGE  4'd13
`define ALU_BLTU 4'd14
`define ALU_BGEU 4'd15
`endif

module tb_alu_exec;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  in_valid = 1'b0;
  logic                  in_ready;
  logic [`ALU_SEL_W-1:0] ALUCtl = '0;
  logic [31:0]           a = '0;
  logic [31:0]           b = '0;
  logic                  out_valid;
  logic                  out_ready = 1'b0;
  logic [31:0]           result;
  logic                  zero;
  logic                  br_taken;
  logic                  err;

  int checks = 0;
  int failures = 0;

  alu_exec #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ALUCtl(ALUCtl), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .br_taken(br_taken), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] res;
    logic        br;
    logic        er;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit is_shift_op(input logic [3:0] op);
    return (op == `ALU_SLL) || (op == `ALU_SRL) || (op == `ALU_SRA);
  endfunction

  // Reference behaviour written directly from the operation definitions.
  function automatic void ref_alu(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] r, output logic br, output logic e);
    int sx, sy;
    sx = x;
    sy = y;
    r  = 0;
    br = 0;
    e  = 0;
    case (op)
      `ALU_ADD:  r = x + y;
      `ALU_SUB:  begin r = x - y; br = (x == y); end
      `ALU_XOR:  r = x ^ y;
      `ALU_OR:   r = x | y;
      `ALU_AND:  r = x & y;
      `ALU_SLL:  r = x << y[4:0];
      `ALU_SRL:  r = x >> y[4:0];
      `ALU_SRA:  r = sx >>> y[4:0];
      `ALU_SLT:  r = (sx < sy) ? 1 : 0;
      `ALU_SLTU: r = (x < y) ? 1 : 0;
      `ALU_BNE:  begin br = (x != y); r = {31'b0, br}; end
      `ALU_BLT:  begin br = (sx < sy); r = {31'b0, br}; end
      `ALU_BGE:  begin br = (sx >= sy); r = {31'b0, br}; end
      `ALU_BLTU: begin br = (x < y); r = {31'b0, br}; end
      `ALU_BGEU: begin br = (x >= y); r = {31'b0, br}; end
      default:   e = 1;
    endcase
  endfunction

  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] er, input logic eb,
                        input logic ee);
    int guard;
    int lat;
    int exp_lat;
    bit leak;
    exp_lat = is_shift_op(op) ? int'(y[4:0]) + 1 : 1;
    out_ready = 1'b1;
    guard = 0;
    while (!in_ready && guard < 100) begin
      tick();
      guard++;
    end
    if (guard >= 100) chk({tag, ".ready_timeout"}, 1, 0);
    ALUCtl   = op;
    a        = x;
    b        = y;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat  = 1;
    leak = 0;
    while (!out_valid && lat < 64) begin
      if (in_ready) leak = 1;
      tick();
      lat++;
    end
    chk({tag, ".latency"}, lat, exp_lat);
    chk({tag, ".result"}, result, er);
    chk({tag, ".zero"}, zero, (er == 0));
    chk({tag, ".br_taken"}, br_taken, eb);
    chk({tag, ".err"}, err, ee);
    chk({tag, ".ready_in_shift"}, leak, 0);
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] er;
    logic        eb;
    logic        ee;
    logic [3:0]  op;
    logic [31:0] x;
    logic [31:0] y;
    bit          stable;
    bit          seen;

    vecs.push_back('{"add_wrap",   `ALU_ADD,  32'hFFFFFFFF, 32'd1,        32'h00000000, 1'b0, 1'b0});
    vecs.push_back('{"sra_31",     `ALU_SRA,  32'h80000000, 32'd31,       32'hFFFFFFFF, 1'b0, 1'b0});
    vecs.push_back('{"blt_neg",    `ALU_BLT,  32'hFFFFFFFF, 32'd1,        32'h00000001, 1'b1, 1'b0});
    vecs.push_back('{"bltu_big",   `ALU_BLTU, 32'hFFFFFFFF, 32'd1,        32'h00000000, 1'b0, 1'b0});
    vecs.push_back('{"sub_eq",     `ALU_SUB,  32'd5,        32'd5,        32'h00000000, 1'b1, 1'b0});
    vecs.push_back('{"sub_neg",    `ALU_SUB,  32'd3,        32'd5,        32'hFFFFFFFE, 1'b0, 1'b0});
    vecs.push_back('{"xor",        `ALU_XOR,  32'h0000F0F0, 32'h0000FF00, 32'h00000FF0, 1'b0, 1'b0});
    vecs.push_back('{"or",         `ALU_OR,   32'h0000F0F0, 32'h0000FF00, 32'h0000FFF0, 1'b0, 1'b0});
    vecs.push_back('{"and",        `ALU_AND,  32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 1'b0, 1'b0});
    vecs.push_back('{"sll_31",     `ALU_SLL,  32'd1,        32'd31,       32'h80000000, 1'b0, 1'b0});
    vecs.push_back('{"sll_amt5",   `ALU_SLL,  32'd1,        32'h00000025, 32'h00000020, 1'b0, 1'b0});
    vecs.push_back('{"srl_4",      `ALU_SRL,  32'h80000000, 32'd4,        32'h08000000, 1'b0, 1'b0});
    vecs.push_back('{"sra_0",      `ALU_SRA,  32'h80000000, 32'd0,        32'h80000000, 1'b0, 1'b0});
    vecs.push_back('{"slt",        `ALU_SLT,  32'hFFFFFFFF, 32'd1,        32'h00000001, 1'b0, 1'b0});
    vecs.push_back('{"sltu",       `ALU_SLTU, 32'hFFFFFFFF, 32'd1,        32'h00000000, 1'b0, 1'b0});
    vecs.push_back('{"bne_eq",     `ALU_BNE,  32'd7,        32'd7,        32'h00000000, 1'b0, 1'b0});
    vecs.push_back('{"bge_neg",    `ALU_BGE,  32'h80000000, 32'd0,        32'h00000000, 1'b0, 1'b0});
    vecs.push_back('{"bgeu_big",   `ALU_BGEU, 32'h80000000, 32'd0,        32'h00000001, 1'b1, 1'b0});
    vecs.push_back('{"bad_code",   4'd0,      32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b0, 1'b1});

    // Reset: a pending request must not be taken and all outputs read cleared.
    ALUCtl    = `ALU_ADD;
    a         = 32'd1;
    b         = 32'd1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    repeat (3) tick();
    chk("rst.in_ready", in_ready, 0);
    chk("rst.out_valid", out_valid, 0);
    chk("rst.result", result, 0);
    chk("rst.zero", zero, 0);
    chk("rst.br_taken", br_taken, 0);
    chk("rst.err", err, 0);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    #1;
    chk("rst.ready_after", in_ready, 1);
    tick();

    foreach (vecs[i])
      run_op(vecs[i].name, vecs[i].op, vecs[i].x, vecs[i].y, vecs[i].res, vecs[i].br, vecs[i].er);

    for (int i = 0; i < 150; i++) begin
      op = 4'($urandom_range(0, 15));
      x  = $urandom;
      y  = $urandom;
      if ($urandom_range(0, 3) == 0) y = x;
      ref_alu(op, x, y, er, eb, ee);
      run_op($sformatf("rand%0d_op%0d", i, op), op, x, y, er, eb, ee);
    end

    // Stall in DONE while a second request waits.
    out_ready = 1'b0;
    ALUCtl    = `ALU_SUB;
    a         = 32'd5;
    b         = 32'd5;
    in_valid  = 1'b1;
    tick();
    ALUCtl = `ALU_ADD;
    a      = 32'd1;
    b      = 32'd2;
    stable = 1;
    for (int i = 0; i < 5; i++) begin
      if (!out_valid || result !== 32'd0 || !zero || !br_taken || in_ready) stable = 0;
      tick();
    end
    chk("stall.held_stable", stable, 1);
    out_ready = 1'b1;
    #1;
    chk("stall.ready_on_out_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("stall.next_valid", out_valid, 1);
    chk("stall.next_result", result, 32'd3);
    chk("stall.next_br", br_taken, 0);
    tick();
    chk("stall.idle", out_valid, 0);

    // Back-to-back throughput.
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      ALUCtl   = `ALU_ADD;
      a        = 32'(k * 3);
      b        = 32'(100 + k);
      in_valid = 1'b1;
      #1;
      chk($sformatf("b2b%0d.in_ready", k), in_ready, 1);
      tick();
      chk($sformatf("b2b%0d.valid", k), out_valid, 1);
      chk($sformatf("b2b%0d.result", k), result, 32'(k * 3 + 100 + k));
    end
    in_valid = 1'b0;
    tick();
    chk("b2b.drain", out_valid, 0);

    // Reset in the middle of a long shift.
    ALUCtl   = `ALU_SLL;
    a        = 32'd1;
    b        = 32'd20;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) seen = 1;
      tick();
    end
    rst_n = 1'b0;
    tick();
    chk("abort.in_ready_low", in_ready, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (out_valid) seen = 1;
      tick();
    end
    chk("abort.no_result", seen, 0);
    run_op("abort.add", `ALU_ADD, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
